// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a start/busy/done handshake.
//
// A request is accepted on a rising edge where start=1 and busy=0. The
// operands and op code are captured on that edge, so later input changes
// do not affect the operation. Single-cycle ops return their result on the
// following edge. MUL runs a shift-add multiplier for N_ALU edges.
//
// Ports:
//   clk    - single clock, rising edge
//   rst    - synchronous active-high reset, has priority over start
//   start  - request, accepted when busy=0 (including the done cycle)
//   dia    - operand A, unsigned, N_ALU bits
//   dib    - operand B, unsigned, N_ALU bits
//   op     - 4-bit operation code
//   busy   - operation in progress; start is ignored while high
//   done   - one-cycle pulse; dout and flags are valid from this cycle
//   dout   - registered result, held between done pulses
//   err    - illegal op code flag
//   zero   - comparison result flag
//   of     - carry / borrow / multiply overflow flag
module alu_seq #(
   parameter int N_ALU = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N_ALU-1:0] dia,
   input  logic [N_ALU-1:0] dib,
   input  logic [3:0]       op,
   output logic             busy,
   output logic             done,
   output logic [N_ALU-1:0] dout,
   output logic             err,
   output logic             zero,
   output logic             of
);

   localparam int CNT_W = $clog2(N_ALU);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ALU - 1);
   localparam logic [N_ALU:0] SHIFT_LIMIT = (N_ALU + 1)'(N_ALU);
   localparam logic [3:0] OP_MUL = 4'b0111;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      MUL
   } state_t;

   state_t state;
   state_t state_next;

   logic [N_ALU-1:0]   a_reg;
   logic [N_ALU-1:0]   b_reg;
   logic [3:0]         op_reg;

   logic [2*N_ALU-1:0] mcand;
   logic [N_ALU-1:0]   mplier;
   logic [2*N_ALU-1:0] acc;
   logic [CNT_W-1:0]   cnt;

   logic               accept;
   logic               mul_last;
   logic [2*N_ALU-1:0] addend;
   logic [2*N_ALU-1:0] acc_next;

   logic [N_ALU-1:0]   exec_dout;
   logic               exec_err;
   logic               exec_zero;
   logic               exec_of;

   // busy follows the state register directly, so it drops in the same
   // cycle that done rises and a new start can be taken right away.
   assign busy     = (state != IDLE);
   assign accept   = start && (state == IDLE);
   assign mul_last = (state == MUL) && (cnt == CNT_LAST);

   // One shift-add step: add the shifted multiplicand when the current
   // multiplier bit is set.
   assign addend   = mplier[0] ? mcand : '0;
   assign acc_next = acc + addend;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. MUL stays for N_ALU edges, every other op takes one.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (op == OP_MUL) ? MUL : EXEC;
            end
         end
         EXEC: begin
            state_next = IDLE;
         end
         MUL: begin
            if (cnt == CNT_LAST) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Single-cycle result computed from the latched operands. Every flag
   // starts at 0 so that each update clears the flags the op does not set.
   always_comb begin
      exec_dout = '0;
      exec_err  = 1'b0;
      exec_zero = 1'b0;
      exec_of   = 1'b0;
      case (op_reg)
         4'b0000: {exec_of, exec_dout} = {1'b0, a_reg} + {1'b0, b_reg};
         // The extra top bit of the widened subtraction is the borrow.
         4'b0001: {exec_of, exec_dout} = {1'b0, a_reg} - {1'b0, b_reg};
         4'b0010: exec_dout = ({1'b0, b_reg} >= SHIFT_LIMIT) ? '0 : (a_reg << b_reg);
         4'b0011: exec_dout = ({1'b0, b_reg} >= SHIFT_LIMIT) ? '0 : (a_reg >> b_reg);
         4'b0100: exec_zero = (a_reg == b_reg);
         4'b0101: exec_zero = (a_reg > b_reg);
         4'b0110: exec_zero = (a_reg < b_reg);
         // MUL is handled by the iterative datapath and never reaches EXEC.
         4'b0111: exec_dout = '0;
         4'b1000: exec_dout = a_reg & b_reg;
         4'b1001: exec_dout = a_reg | b_reg;
         4'b1010: exec_dout = a_reg ^ b_reg;
         default: begin
            exec_err  = 1'b1;
            exec_dout = '1;
         end
      endcase
   end

   // Datapath and output registers. Operands are captured on accept; EXEC
   // publishes the single-cycle result, MUL iterates and publishes on its
   // last step. Outputs are only written alongside a done pulse, so they
   // hold their values in between. Reset clears everything and aborts any
   // operation in flight without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg  <= '0;
         b_reg  <= '0;
         op_reg <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         done   <= 1'b0;
         dout   <= '0;
         err    <= 1'b0;
         zero   <= 1'b0;
         of     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            a_reg  <= dia;
            b_reg  <= dib;
            op_reg <= op;
            mcand  <= {{N_ALU{1'b0}}, dia};
            mplier <= dib;
            acc    <= '0;
            cnt    <= '0;
         end else if (state == EXEC) begin
            dout <= exec_dout;
            err  <= exec_err;
            zero <= exec_zero;
            of   <= exec_of;
            done <= 1'b1;
         end else if (state == MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (mul_last) begin
               dout <= acc_next[N_ALU-1:0];
               of   <= |acc_next[2*N_ALU-1:N_ALU];
               err  <= 1'b0;
               zero <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: N_ALU, default 8, operand/result width in bits (N_ALU >= 2).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request; accepted on a rising edge when busy=0.
REQ-005 Port: dia  input  N_ALU  operand A, unsigned; sampled only on accept edge.
REQ-006 Port: dib  input  N_ALU  operand B, unsigned; sampled only on accept edge.
REQ-007 Port: op  input  4  operation code; sampled only on accept edge.
REQ-008 Port: busy  output  1  operation in progress; start ignored while high.
REQ-009 Port: done  output  1  one-cycle pulse; dout/flags valid from this cycle.
REQ-010 Port: dout  output  N_ALU  registered result.
REQ-011 Port: err  output  1  illegal op flag.
REQ-012 Port: zero  output  1  comparison result flag.
REQ-013 Port: of  output  1  carry/borrow/overflow flag.

Function
REQ-014 FSM states IDLE, EXEC, MUL; IDLE->EXEC on accept with op!=0111; IDLE->MUL on accept with op=0111; EXEC->IDLE after 1 cycle; MUL->IDLE after N_ALU iteration cycles.
REQ-015 Accept edge = edge 0: dia/dib/op latched internally; later input changes do not affect the operation.
REQ-016 Non-MUL ops: dout, flags and done=1 registered at edge 1; busy high only in the cycle between edge 0 and edge 1.
REQ-017 MUL: one shift-add iteration per edge 1..N_ALU; dout, of and done=1 registered at edge N_ALU; busy high from edge 0 until edge N_ALU.
REQ-018 done high exactly one cycle per accepted operation; busy=0 whenever done=1.
REQ-019 start high in the done cycle is accepted (back-to-back, no idle bubble).
REQ-020 start while busy=1 is ignored and not queued.
REQ-021 On every result update all of err, zero, of are written: each flag is 0 unless its op sets it.
REQ-022 0000 ADD: {of,dout} = dia+dib, of = carry out of bit N_ALU-1.
REQ-023 0001 SUB: dout = (dia-dib) mod 2^N_ALU, of = borrow (dia<dib).
REQ-024 0010 SHL: dout = dia<<dib, 0 if dib>=N_ALU; of=0.
REQ-025 0011 SHR: logical dia>>dib, 0 if dib>=N_ALU; of=0.
REQ-026 0100 EQ / 0101 GT / 0110 LT: zero = (dia==dib)/(dia>dib)/(dia<dib); dout = 0 (never X).
REQ-027 0111 MUL: unsigned product, 2*N_ALU bits internal; dout = low N_ALU bits; of = OR of high N_ALU bits.
REQ-028 1000 AND, 1001 OR, 1010 XOR: bitwise; flags 0.
REQ-029 1011-1111: err=1, dout = all ones, zero=of=0; latency as non-MUL.
REQ-030 dout and flags hold their last values between done pulses.

Reset
REQ-031 rst=1 at an edge: state IDLE, busy=0, done=0, dout=0, err=0, zero=0, of=0; rst has priority over start.
REQ-032 rst during EXEC or MUL aborts the operation; no done pulse is produced for it.
REQ-033 First edge with rst=0 may accept start.

Verification (N_ALU=8)
REQ-034 ADD dia=200, dib=100, start 1 cycle -> done at edge 1, dout=44, of=1, err=zero=0.
REQ-035 SUB dia=4, dib=5 -> dout=255, of=1; then SUB dia=5, dib=4 back-to-back in the done cycle -> dout=1, of=0 one edge later.
REQ-036 MUL dia=16, dib=17 -> busy 8 cycles, done at edge 8, dout=16, of=1; MUL 12*10 -> dout=120, of=0.
REQ-037 EQ dia=dib=2 -> zero=1, dout=0; GT then LT same operands -> zero=0 each; op=1111 -> err=1, dout=255.
REQ-038 start with new operands during MUL busy -> ignored, MUL result unchanged, single done.
REQ-039 rst asserted at MUL edge 4 -> all outputs 0 next edge, no done; fresh ADD 1+1 after release -> dout=2.
